// File: rtl/shared_net_arbiter_if.sv
// Signal bundle between the requesters and the shared-net arbiter.
//
// Requester side (master modport) drives:
//   req       [NREQ-1:0]   level request, bit i = requester i
//   din       [NREQ*W-1:0] requester data, slice i = din[i*W +: W]
// Arbiter side (slave modport) drives:
//   grant     [NREQ-1:0]   one-hot registered ownership, including turnaround
//   drv_en    [NREQ-1:0]   one-hot driver enable, equals grant only while owning
//   owner_id  [IDW-1:0]    index of the current grant, 0 when none
//   bus_data  [W-1:0]      din slice of the enabled owner, 0 when nobody drives
//   bus_valid              high iff any drv_en bit is high
//   preempt                one-cycle pulse when an owner is forcibly revoked
interface shared_net_arbiter_if #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned W    = 12
) ();

  localparam int unsigned IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]   req;
  logic [NREQ*W-1:0] din;
  logic [NREQ-1:0]   grant;
  logic [NREQ-1:0]   drv_en;
  logic [IDW-1:0]    owner_id;
  logic [W-1:0]      bus_data;
  logic              bus_valid;
  logic              preempt;

  modport master (
    output req,
    output din,
    input  grant,
    input  drv_en,
    input  owner_id,
    input  bus_data,
    input  bus_valid,
    input  preempt
  );

  modport slave (
    input  req,
    input  din,
    output grant,
    output drv_en,
    output owner_id,
    output bus_data,
    output bus_valid,
    output preempt
  );

endinterface

// File: rtl/shared_net_arbiter.sv
// Round-robin owner arbiter for one shared, multi-driven W-bit net.
//
// At most one requester drives the net at a time. Every ownership change
// passes through TURN cycles with all drivers off (at least one cycle of
// drv_en=0 even when TURN=0), so two drivers never fight on the net. An
// owner that reaches MAXHOLD consecutive owning cycles while somebody else
// is waiting is revoked and preempt pulses for one cycle.
//
// Ports:
//   clk   rising-edge clock
//   rst   synchronous, active-high reset
//   bus   shared_net_arbiter_if.slave: req/din in; grant, drv_en, owner_id,
//         preempt (registered) and bus_data/bus_valid (mux on registered
//         drv_en) out
module shared_net_arbiter #(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned W       = 12,
  parameter int unsigned TURN    = 1,
  parameter int unsigned MAXHOLD = 16
) (
  input logic                 clk,
  input logic                 rst,
  shared_net_arbiter_if.slave bus
);

  localparam int unsigned IdW   = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned HoldW = $clog2(MAXHOLD);
  localparam logic [HoldW-1:0] HoldLast = HoldW'(MAXHOLD - 1);
  localparam logic [2:0]       TurnLast = (TURN > 0) ? 3'(TURN - 1) : 3'd0;
  localparam logic [IdW-1:0]   PtrRst   = IdW'(NREQ - 1);

  typedef enum logic [1:0] {
    StIdle,
    StTurn,
    StOwn
  } state_e;

  state_e            state_q, state_d;
  logic [NREQ-1:0]   grant_q, grant_d;
  logic [NREQ-1:0]   drv_en_q, drv_en_d;
  logic [IdW-1:0]    owner_id_q, owner_id_d;
  logic [IdW-1:0]    rr_ptr_q, rr_ptr_d;
  logic              preempt_q, preempt_d;
  logic [HoldW-1:0]  hold_cnt_q, hold_cnt_d;
  logic [2:0]        turn_cnt_q, turn_cnt_d;

  logic [NREQ-1:0]   cand;
  logic              any_cand;
  logic              owner_req;
  logic              pick_found;
  logic [IdW-1:0]    pick_idx;
  logic [NREQ-1:0]   pick_onehot;
  int unsigned       scan;
  logic [W-1:0]      bus_data_c;

  // Masking with the current grant excludes the owner from its own
  // preemption pick; on release the owner's req is already 0 and in
  // IDLE/TURN the mask is either empty or irrelevant, so one pick serves all.
  assign cand      = bus.req & ~grant_q;
  assign any_cand  = |cand;
  assign owner_req = |(bus.req & grant_q);

  // Round-robin search starting just above rr_ptr, wrapping at NREQ.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    scan       = 0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      scan = 32'(rr_ptr_q) + k;
      if (scan >= NREQ) begin
        scan = scan - NREQ;
      end
      if (!pick_found && cand[scan[IdW-1:0]]) begin
        pick_found = 1'b1;
        pick_idx   = scan[IdW-1:0];
      end
    end
  end

  assign pick_onehot = NREQ'(1) << pick_idx;

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    drv_en_d   = drv_en_q;
    owner_id_d = owner_id_q;
    rr_ptr_d   = rr_ptr_q;
    preempt_d  = 1'b0;
    hold_cnt_d = hold_cnt_q;
    turn_cnt_d = turn_cnt_q;

    unique case (state_q)
      StIdle: begin
        drv_en_d = '0;
        if (any_cand) begin
          grant_d    = pick_onehot;
          owner_id_d = pick_idx;
          rr_ptr_d   = pick_idx;
          hold_cnt_d = '0;
          turn_cnt_d = '0;
          if (TURN == 0) begin
            // Nobody was driving, so no gap is needed from idle.
            state_d  = StOwn;
            drv_en_d = pick_onehot;
          end else begin
            state_d = StTurn;
          end
        end
      end

      StTurn: begin
        drv_en_d = '0;
        if (!owner_req) begin
          // Grantee lost interest before ever driving: quietly drop it.
          state_d    = StIdle;
          grant_d    = '0;
          owner_id_d = '0;
          turn_cnt_d = '0;
        end else if (turn_cnt_q == TurnLast) begin
          state_d    = StOwn;
          drv_en_d   = grant_q;
          hold_cnt_d = '0;
          turn_cnt_d = '0;
        end else begin
          turn_cnt_d = turn_cnt_q + 3'd1;
        end
      end

      StOwn: begin
        // Release takes priority over the hold limit, so a voluntary drop
        // on the limit cycle never shows up as a preemption.
        if (!owner_req || (hold_cnt_q == HoldLast && any_cand)) begin
          preempt_d  = owner_req;
          drv_en_d   = '0;
          hold_cnt_d = '0;
          turn_cnt_d = '0;
          if (any_cand) begin
            grant_d    = pick_onehot;
            owner_id_d = pick_idx;
            rr_ptr_d   = pick_idx;
            // With TURN=0 the new owner enters OWN with drv_en still 0 for
            // one cycle, keeping a break-before-make gap on every handover.
            state_d    = (TURN == 0) ? StOwn : StTurn;
          end else begin
            state_d    = StIdle;
            grant_d    = '0;
            owner_id_d = '0;
          end
        end else begin
          drv_en_d = grant_q;
          if (hold_cnt_q != HoldLast) begin
            hold_cnt_d = hold_cnt_q + HoldW'(1);
          end
        end
      end

      default: begin
        state_d    = StIdle;
        grant_d    = '0;
        drv_en_d   = '0;
        owner_id_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      grant_q    <= '0;
      drv_en_q   <= '0;
      owner_id_q <= '0;
      rr_ptr_q   <= PtrRst;
      preempt_q  <= 1'b0;
      hold_cnt_q <= '0;
      turn_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      drv_en_q   <= drv_en_d;
      owner_id_q <= owner_id_d;
      rr_ptr_q   <= rr_ptr_d;
      preempt_q  <= preempt_d;
      hold_cnt_q <= hold_cnt_d;
      turn_cnt_q <= turn_cnt_d;
    end
  end

  // AND-OR mux on the registered one-hot enable models the resolved net.
  always_comb begin
    bus_data_c = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (drv_en_q[i]) begin
        bus_data_c = bus_data_c | bus.din[i*W +: W];
      end
    end
  end

  assign bus.grant     = grant_q;
  assign bus.drv_en    = drv_en_q;
  assign bus.owner_id  = owner_id_q;
  assign bus.preempt   = preempt_q;
  assign bus.bus_data  = bus_data_c;
  assign bus.bus_valid = |drv_en_q;

endmodule

// File: tb/tb_shared_net_arbiter.sv
// Bench for shared_net_arbiter (NREQ=4, W=12, TURN=1, MAXHOLD=16).
// Stimulus pushes the expected ownership tenures (enable, data, length);
// a negedge monitor pops one per tenure and also checks bus invariants.
module tb_shared_net_arbiter;

  localparam int unsigned NREQ    = 4;
  localparam int unsigned W       = 12;
  localparam int unsigned TURN    = 1;
  localparam int unsigned MAXHOLD = 16;

  localparam logic [NREQ*W-1:0] DinVec = {12'h4D4, 12'h3C3, 12'h2B2, 12'h1A1};

  typedef struct {
    logic [3:0]  drv;
    logic [11:0] data;
    int          len;
  } tenure_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;

  tenure_t exp_q[$];

  always #5 clk = ~clk;

  shared_net_arbiter_if #(.NREQ(NREQ), .W(W)) bus_if ();

  shared_net_arbiter #(
    .NREQ   (NREQ),
    .W      (W),
    .TURN   (TURN),
    .MAXHOLD(MAXHOLD)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus_if)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_to(input int target);
    while (cyc < target) tick();
  endtask

  task automatic push(input logic [3:0] drv, input logic [11:0] data, input int len);
    tenure_t t;
    t.drv  = drv;
    t.data = data;
    t.len  = len;
    exp_q.push_back(t);
  endtask

  task automatic apply_reset();
    rst        = 1'b1;
    bus_if.req = '0;
    tick();
    tick();
    rst = 1'b0;
    cyc = 0;
  endtask

  task automatic wait_drv(output int n);
    n = 0;
    while (bus_if.drv_en == '0 && n < 20) begin
      tick();
      n++;
    end
    if (bus_if.drv_en == '0) begin
      n_tests++;
      n_fail++;
      $display("FAIL wait_drv: got no drv_en within %0d cycles, expected an owner", n);
    end
  endtask

  // Monitor: invariants every cycle, one scoreboard entry per tenure.
  logic [3:0] prev_drv = '0;
  logic       in_ten   = 1'b0;
  int         ten_len  = 0;
  tenure_t    cur;

  always @(negedge clk) begin
    if (!$isunknown(bus_if.drv_en)) begin
      check("drv_onehot0", 32'($onehot0(bus_if.drv_en)), 32'd1);
      check("drv_subset_grant", 32'(bus_if.drv_en & ~bus_if.grant), 32'd0);
      check("bus_valid_or", 32'(bus_if.bus_valid), 32'(|bus_if.drv_en));
      if (prev_drv != '0 && bus_if.drv_en != '0) begin
        check("drv_no_direct_swap", 32'(bus_if.drv_en), 32'(prev_drv));
      end
      if (!bus_if.bus_valid) begin
        check("bus_data_idle", 32'(bus_if.bus_data), 32'd0);
      end
      if (bus_if.bus_valid && !in_ten) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_tenure: got drv_en=%b, expected no owner", bus_if.drv_en);
          cur.drv  = bus_if.drv_en;
          cur.data = bus_if.bus_data;
          cur.len  = 0;
        end else begin
          cur = exp_q.pop_front();
          check("tenure_owner", 32'(bus_if.drv_en), 32'(cur.drv));
          check("tenure_data", 32'(bus_if.bus_data), 32'(cur.data));
        end
        in_ten  = 1'b1;
        ten_len = 1;
      end else if (bus_if.bus_valid) begin
        ten_len++;
      end else if (in_ten) begin
        check("tenure_len", 32'(ten_len), 32'(cur.len));
        in_ten = 1'b0;
      end
      prev_drv = bus_if.drv_en;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish by 200000, expected finish");
    $fatal(1, "watchdog");
  end

  logic [3:0] rr_exp [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

  initial begin
    int n;
    bus_if.req = '0;
    bus_if.din = DinVec;
    apply_reset();

    // Reset state
    check("rst_grant", 32'(bus_if.grant), 32'd0);
    check("rst_drv_en", 32'(bus_if.drv_en), 32'd0);
    check("rst_owner_id", 32'(bus_if.owner_id), 32'd0);
    check("rst_preempt", 32'(bus_if.preempt), 32'd0);
    check("rst_bus_valid", 32'(bus_if.bus_valid), 32'd0);
    check("rst_bus_data", 32'(bus_if.bus_data), 32'd0);

    // Basic grant: grant one cycle after req, drv_en TURN cycles later
    push(4'b0001, 12'h1A1, 3);
    bus_if.req = 4'b0001;
    tick();
    check("basic_grant", 32'(bus_if.grant), 32'b0001);
    check("basic_turn_drv", 32'(bus_if.drv_en), 32'd0);
    tick();
    check("basic_drv", 32'(bus_if.drv_en), 32'b0001);
    check("basic_data", 32'(bus_if.bus_data), 32'h1A1);
    tick();
    tick();
    bus_if.req = '0;
    tick();
    check("basic_release_grant", 32'(bus_if.grant), 32'd0);
    check("basic_release_drv", 32'(bus_if.drv_en), 32'd0);
    tick();

    // Round-robin with all requesting; each owner drops for one cycle
    apply_reset();
    for (int t = 0; t < 5; t++) push(rr_exp[t], (t == 1) ? 12'h2B2 : (t == 2) ? 12'h3C3 :
                                     (t == 3) ? 12'h4D4 : 12'h1A1, 3);
    bus_if.req = 4'b1111;
    for (int t = 0; t < 5; t++) begin
      wait_drv(n);
      check("rr_gap", 32'(n), (t == 0) ? 32'd2 : 32'd1);
      check("rr_owner", 32'(bus_if.drv_en), 32'(rr_exp[t]));
      tick();
      tick();
      bus_if.req = (t == 4) ? 4'b0000 : (4'b1111 & ~bus_if.drv_en);
      tick();
      check("rr_handover_off", 32'(bus_if.drv_en), 32'd0);
      bus_if.req = (t == 4) ? 4'b0000 : 4'b1111;
    end
    tick();
    tick();

    // Preemption after 16 owning cycles while requester 2 waits
    apply_reset();
    push(4'b0001, 12'h1A1, 16);
    push(4'b0100, 12'h3C3, 3);
    bus_if.req = 4'b0001;
    run_to(5);
    bus_if.req = 4'b0101;
    n = 0;
    while (!bus_if.preempt && n < 40) begin
      tick();
      n++;
    end
    check("pre_cycle", 32'(cyc), 32'd18);
    check("pre_pulse", 32'(bus_if.preempt), 32'd1);
    check("pre_grant", 32'(bus_if.grant), 32'b0100);
    check("pre_owner_id", 32'(bus_if.owner_id), 32'd2);
    check("pre_drv_off", 32'(bus_if.drv_en), 32'd0);
    tick();
    check("pre_pulse_end", 32'(bus_if.preempt), 32'd0);
    check("pre_new_drv", 32'(bus_if.drv_en), 32'b0100);
    check("pre_new_data", 32'(bus_if.bus_data), 32'h3C3);
    tick();
    tick();
    bus_if.req = '0;
    tick();
    tick();

    // Release on the hold-limit cycle counts as a release
    apply_reset();
    push(4'b0001, 12'h1A1, 16);
    push(4'b0010, 12'h2B2, 2);
    bus_if.req = 4'b0001;
    run_to(5);
    bus_if.req = 4'b0011;
    run_to(17);
    check("rel_still_owner", 32'(bus_if.drv_en), 32'b0001);
    bus_if.req = 4'b0010;
    tick();
    check("rel_no_preempt", 32'(bus_if.preempt), 32'd0);
    check("rel_grant", 32'(bus_if.grant), 32'b0010);
    check("rel_drv_off", 32'(bus_if.drv_en), 32'd0);
    tick();
    check("rel_new_drv", 32'(bus_if.drv_en), 32'b0010);
    tick();
    bus_if.req = '0;
    tick();
    tick();

    // Request dropped during turnaround
    apply_reset();
    bus_if.req = 4'b1000;
    tick();
    check("tdrop_grant", 32'(bus_if.grant), 32'b1000);
    check("tdrop_drv", 32'(bus_if.drv_en), 32'd0);
    bus_if.req = '0;
    tick();
    check("tdrop_grant_clr", 32'(bus_if.grant), 32'd0);
    check("tdrop_preempt", 32'(bus_if.preempt), 32'd0);
    for (int i = 0; i < 3; i++) begin
      check("tdrop_drv_stays_off", 32'(bus_if.drv_en), 32'd0);
      tick();
    end

    // Reset while owning, then rr_ptr back at NREQ-1
    apply_reset();
    push(4'b0010, 12'h2B2, 1);
    push(4'b0010, 12'h2B2, 1);
    bus_if.req = 4'b0010;
    tick();
    tick();
    check("mid_drv", 32'(bus_if.drv_en), 32'b0010);
    rst = 1'b1;
    tick();
    check("mid_rst_grant", 32'(bus_if.grant), 32'd0);
    check("mid_rst_drv", 32'(bus_if.drv_en), 32'd0);
    check("mid_rst_owner_id", 32'(bus_if.owner_id), 32'd0);
    check("mid_rst_preempt", 32'(bus_if.preempt), 32'd0);
    check("mid_rst_valid", 32'(bus_if.bus_valid), 32'd0);
    check("mid_rst_data", 32'(bus_if.bus_data), 32'd0);
    rst        = 1'b0;
    bus_if.req = 4'b1010;
    tick();
    check("post_rst_grant", 32'(bus_if.grant), 32'b0010);
    check("post_rst_owner_id", 32'(bus_if.owner_id), 32'd1);
    tick();
    check("post_rst_drv", 32'(bus_if.drv_en), 32'b0010);
    bus_if.req = '0;
    tick();
    check("post_rst_release", 32'(bus_if.drv_en), 32'd0);
    tick();
    tick();

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    check("no_open_tenure", 32'(in_ten), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
